// File: rtl/button_conditioner_pkg.sv
// Shared constants and channel state encoding for the 7-segment button front end.
package seg7_fun_pkg;

  localparam int DEF_DEBOUNCE_VAL = 20000;
  localparam int DEF_REPEAT_DELAY = 5_000_000;
  localparam int DEF_REPEAT_RATE  = 2_000_000;
  localparam logic [3:0] DEF_REPEAT_MASK = 4'b1100;

  // Button channel assignment on ui_in[3:0]
  localparam int BTN_INC_ANI = 0;
  localparam int BTN_DEC_ANI = 1;
  localparam int BTN_INC_SPD = 2;
  localparam int BTN_DEC_SPD = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD_DLY = 2'd1,
    ST_REPEAT   = 2'd2
  } chan_state_t;

endpackage

// File: rtl/button_conditioner_chan.sv
// One button channel: 2-FF sync, debounce counter, edge pulses, auto-repeat FSM.
module btn_chan
  import seg7_fun_pkg::*;
#(
  parameter int DEB_W        = 16,
  parameter int DEBOUNCE_VAL = DEF_DEBOUNCE_VAL,
  parameter int RPT_W        = 24,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter bit RPT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_VAL - 1);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

  logic             sync_q1, sync_q2;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_diff, deb_done, rise, fall;
  chan_state_t      state, state_next;
  logic [RPT_W-1:0] rpt_cnt, rpt_next;
  logic             press_next;

  // Debounce decode: level flips once the synced input has differed long enough
  always_comb begin
    deb_diff = (sync_q2 != btn_level);
    deb_done = deb_diff && (deb_cnt == DEB_LAST);
    rise     = deb_done && !btn_level;
    fall     = deb_done && btn_level;
  end

  // Synchronizer, debounce counter and debounced level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      deb_cnt   <= '0;
      btn_level <= 1'b0;
    end else begin
      sync_q1   <= btn_raw;
      sync_q2   <= sync_q1;
      deb_cnt   <= (deb_diff && !deb_done) ? deb_cnt + 1'b1 : '0;
      btn_level <= btn_level ^ deb_done;
    end
  end

  // Repeat FSM next-state; release always wins over a repeat pulse in the same cycle
  always_comb begin
    state_next = state;
    rpt_next   = rpt_cnt;
    press_next = rise;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_next = ST_HOLD_DLY;
          rpt_next   = '0;
        end
      end
      ST_HOLD_DLY: begin
        if (fall) begin
          state_next = ST_IDLE;
          rpt_next   = '0;
        end else if (RPT_EN) begin
          if (rpt_cnt == DLY_LAST) begin
            state_next = ST_REPEAT;
            rpt_next   = '0;
            press_next = 1'b1;
          end else begin
            rpt_next = rpt_cnt + 1'b1;
          end
        end
      end
      ST_REPEAT: begin
        if (fall) begin
          state_next = ST_IDLE;
          rpt_next   = '0;
        end else if (rpt_cnt == RATE_LAST) begin
          rpt_next   = '0;
          press_next = 1'b1;
        end else begin
          rpt_next = rpt_cnt + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        rpt_next   = '0;
      end
    endcase
  end

  // FSM state, repeat counter and registered pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rpt_cnt     <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_next;
      rpt_cnt     <= rpt_next;
      btn_press   <= press_next;
      btn_release <= fall;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// N independent button channels feeding clean command pulses to the animation controller.
module button_conditioner
  import seg7_fun_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int DEB_W        = 16,
  parameter int DEBOUNCE_VAL = DEF_DEBOUNCE_VAL,
  parameter int RPT_W        = 24,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter logic [N_BTN-1:0] REPEAT_MASK = N_BTN'(DEF_REPEAT_MASK)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  // Terminal counts must be reachable in the chosen counter widths
  if (DEBOUNCE_VAL < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_val
    $error("button_conditioner: DEBOUNCE_VAL/REPEAT_DELAY/REPEAT_RATE must be >= 1");
  end
  if (longint'(DEBOUNCE_VAL) > (longint'(1) << DEB_W)) begin : g_bad_deb
    $error("button_conditioner: DEBOUNCE_VAL does not fit DEB_W");
  end
  if (longint'(REPEAT_DELAY) > (longint'(1) << RPT_W) ||
      longint'(REPEAT_RATE)  > (longint'(1) << RPT_W)) begin : g_bad_rpt
    $error("button_conditioner: repeat interval does not fit RPT_W");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .DEB_W        (DEB_W),
      .DEBOUNCE_VAL (DEBOUNCE_VAL),
      .RPT_W        (RPT_W),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .RPT_EN       (REPEAT_MASK[i])
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: a cycle-level behavioural model predicts every output each cycle.
module tb_button_conditioner;

  localparam int DV   = 4;
  localparam int RD   = 10;
  localparam int RR   = 3;
  localparam logic [3:0] MASK = 4'b1100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_raw = 4'hF;
  logic [3:0] btn_level, btn_press, btn_release;
  logic       any_press;

  typedef struct {
    logic [3:0] lvl;
    logic [3:0] press;
    logic [3:0] rel;
    logic       any;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  button_conditioner #(
    .N_BTN(4), .DEB_W(16), .DEBOUNCE_VAL(DV), .RPT_W(24),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .any_press(any_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: s is raw delayed by two samples; level flips after DV consecutive
  // differing samples; presses at hold time 0, RD, RD+RR, RD+2RR ... for masked channels.
  initial begin : model
    logic [3:0] r1, r2;
    int  run [4];
    bit  lvl [4];
    int  tp  [4];
    int  k, held;
    bit  rise, fall;
    exp_t e;
    r1 = '0; r2 = '0; k = 0;
    for (int i = 0; i < 4; i++) begin run[i] = 0; lvl[i] = 0; tp[i] = 0; end
    forever begin
      @(posedge clk);
      e.lvl = '0; e.press = '0; e.rel = '0;
      if (reset) begin
        r1 = '0; r2 = '0;
        for (int i = 0; i < 4; i++) begin run[i] = 0; lvl[i] = 0; end
      end else begin
        for (int i = 0; i < 4; i++) begin
          rise = 0; fall = 0;
          if (r2[i] != lvl[i]) run[i]++; else run[i] = 0;
          if (run[i] == DV) begin
            run[i] = 0;
            lvl[i] = !lvl[i];
            rise = lvl[i];
            fall = !lvl[i];
            if (rise) tp[i] = k;
          end
          held = k - tp[i];
          e.press[i] = rise || (lvl[i] && MASK[i] && held >= RD && ((held - RD) % RR) == 0);
          e.rel[i] = fall;
          e.lvl[i] = lvl[i];
        end
        r2 = r1;
        r1 = btn_raw;
      end
      k++;
      e.any = |e.press;
      exp_q.push_back(e);
    end
  end

  // Monitor: DUT presents a result every cycle; compare it against the oldest prediction
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("level",   btn_level,   e.lvl);
        check("press",   btn_press,   e.press);
        check("release", btn_release, e.rel);
        check("any",     {3'b000, any_press}, {3'b000, e.any});
      end
    end
  end

  task automatic drive(input logic [3:0] raw, input int n);
    repeat (n) begin
      @(negedge clk);
      #1 btn_raw = raw;
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_level"},   btn_level,   4'h0);
    check({nm, "_press"},   btn_press,   4'h0);
    check({nm, "_release"}, btn_release, 4'h0);
    check({nm, "_any"},     {3'b000, any_press}, 4'h0);
  endtask

  initial begin : stim
    logic [3:0] raw;
    int rem [4];
    // 1: reset with all buttons held, then release reset and keep holding
    repeat (3) @(negedge clk);
    #2 check_zero("rst_hold");
    @(negedge clk);
    #1 reset = 1'b0;
    drive(4'hF, 12);
    drive(4'h0, 12);
    // 2: non-repeating channel held
    drive(4'h1, 20);
    drive(4'h0, 12);
    // 3: bounce then steady press
    drive(4'h1, 1); drive(4'h0, 1); drive(4'h1, 2); drive(4'h0, 1);
    drive(4'h1, 15);
    drive(4'h0, 12);
    // 4: repeating channel held through several repeats
    drive(4'h4, 30);
    drive(4'h0, 15);
    // 5: simultaneous presses
    drive(4'hA, 12);
    drive(4'h0, 12);
    // 6: reset while channel 3 is repeating
    drive(4'h8, 20);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_zero("rst_async");
    drive(4'h8, 3);
    @(negedge clk);
    #1 reset = 1'b0;
    drive(4'h8, 25);
    drive(4'h0, 12);
    // Random hold lengths per channel, including glitches, with one reset in the middle
    raw = 4'h0;
    for (int i = 0; i < 4; i++) rem[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0) begin
          raw[i] = ~raw[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
        end
        rem[i]--;
      end
      @(negedge clk);
      #1 btn_raw = raw;
      if (c == 700) reset = 1'b1;
      if (c == 703) reset = 1'b0;
    end
    drive(4'h0, 20);
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
